// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the spi_frame_tx command-frame transmitter.
// The field offsets describe the DMA_SPI command frame layout, MSB first on the wire.
package spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int FRAME_BITS_DEF = 408;

  // Width of the shared phase down-counter; covers every duration parameter.
  localparam int CNT_W = 16;

  localparam int TIME_MSB         = 407;
  localparam int TIME_LSB         = 344;
  localparam int FREQ_MSB         = 343;
  localparam int FREQ_LSB         = 296;
  localparam int FREQ_STEP_MSB    = 295;
  localparam int FREQ_STEP_LSB    = 248;
  localparam int FREQ_RATE_MSB    = 247;
  localparam int FREQ_RATE_LSB    = 216;
  localparam int TIME_START_MSB   = 215;
  localparam int TIME_START_LSB   = 152;
  localparam int N_IMPULSE_MSB    = 151;
  localparam int N_IMPULSE_LSB    = 136;
  localparam int TYPE_IMPULSE_MSB = 135;
  localparam int TYPE_IMPULSE_LSB = 128;
  localparam int INTERVAL_TI_MSB  = 127;
  localparam int INTERVAL_TI_LSB  = 96;
  localparam int INTERVAL_TP_MSB  = 95;
  localparam int INTERVAL_TP_LSB  = 64;
  localparam int TBLANK1_MSB      = 63;
  localparam int TBLANK1_LSB      = 32;
  localparam int TBLANK2_MSB      = 31;
  localparam int TBLANK2_LSB      = 0;

  function automatic logic [63:0] frame_time(input logic [FRAME_BITS_DEF-1:0] frame);
    return frame[TIME_MSB:TIME_LSB];
  endfunction

endpackage

// File: rtl/spi_tx_phase_cnt.sv
// Shared down-counter timing the SETUP, half-bit, HOLD and GAP phases.
// tc_o flags the last cycle of a phase; one_o flags the cycle before it.
module spi_tx_phase_cnt
  import spi_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (clk_en) begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o  = (cnt_q == {CNT_W{1'b0}});
  assign one_o = (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/spi_frame_tx.sv
// SPI master sending one FRAME_BITS command frame MSB first (CS low, SCLK idle low).
// Optional full-duplex capture of MISO is enabled with SPI_TX_MISO_CAPTURE_EN.
module spi_frame_tx
  import spi_tx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] DATA,
  output logic                  busy,
  output logic                  done,
  output logic                  CS,
  output logic                  SCLK,
  output logic                  MOSI
`ifdef SPI_TX_MISO_CAPTURE_EN
  ,
  input  logic                  MISO,
  output logic [FRAME_BITS-1:0] RX_DATA,
  output logic                  RX_VALID
`endif
);

  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   sreg_q, sreg_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    cs_q, cs_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ld_s;
  logic [CNT_W-1:0]        ld_val_s;
  logic                    tc_s;
  logic                    one_s;
  logic                    last_bit_s;

  spi_tx_phase_cnt u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .load_i     (ld_s),
    .load_val_i (ld_val_s),
    .tc_o       (tc_s),
    .one_o      (one_s)
  );

  assign last_bit_s = (bit_q == LAST_BIT);

  // Frame sequencing: each phase ends on the counter's terminal count and reloads it.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bit_d    = bit_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    ld_s     = 1'b0;
    ld_val_s = {CNT_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETUP;
          sreg_d   = DATA;
          bit_d    = {BIT_W{1'b0}};
          cs_d     = 1'b0;
          mosi_d   = DATA[FRAME_BITS-1];
          busy_d   = 1'b1;
          ld_s     = 1'b1;
          ld_val_s = SETUP_LD;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (tc_s) begin
          state_d  = SHIFT;
          sclk_d   = 1'b1;
          ld_s     = 1'b1;
          ld_val_s = HALF_LD;
        end else begin
          state_d = SETUP;
        end
      end
      SHIFT: begin
        if (tc_s && sclk_q) begin
          // Falling edge: advance the next bit onto MOSI; a zero shifts in behind.
          sclk_d   = 1'b0;
          sreg_d   = {sreg_q[FRAME_BITS-2:0], 1'b0};
          mosi_d   = sreg_q[FRAME_BITS-2];
          ld_s     = 1'b1;
          ld_val_s = HALF_LD;
        end else if (tc_s && last_bit_s) begin
          state_d  = HOLD;
          mosi_d   = 1'b0;
          ld_s     = 1'b1;
          ld_val_s = HOLD_LD;
        end else if (tc_s) begin
          bit_d    = bit_q + {{(BIT_W-1){1'b0}}, 1'b1};
          sclk_d   = 1'b1;
          ld_s     = 1'b1;
          ld_val_s = HALF_LD;
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (tc_s) begin
          state_d  = GAP;
          cs_d     = 1'b1;
          ld_s     = 1'b1;
          ld_val_s = GAP_LD;
        end else begin
          state_d = HOLD;
        end
      end
      GAP: begin
        if (tc_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    // done must be high during the last GAP cycle, so it is set one edge early.
    done_d = ((state_q == HOLD) && tc_s && (CS_GAP == 1)) ||
             ((state_q == GAP) && !tc_s && one_s);
  end

  // Frame state and registered outputs; everything freezes while clk_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= {FRAME_BITS{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CS   = cs_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SPI_TX_MISO_CAPTURE_EN
  logic [FRAME_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q;

  // MISO is taken at the end of each high half; the result is published on HOLD entry.
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    if ((state_q == SHIFT) && tc_s && sclk_q) begin
      rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], MISO};
    end else if ((state_q == SHIFT) && tc_s && last_bit_s) begin
      rx_data_d = rx_sh_q;
    end else begin
      rx_sh_d = rx_sh_q;
    end
  end

  // Receive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sh_q    <= {FRAME_BITS{1'b0}};
      rx_data_q  <= {FRAME_BITS{1'b0}};
      rx_valid_q <= 1'b0;
    end else if (clk_en) begin
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= done_d;
    end
  end

  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
`else
  // Transmit-only build: no receive path.
`endif

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: stimulus queues expected frames, a slave-model
// monitor captures MOSI on SCLK rises and checks each frame when done pulses.
module tb_spi_frame_tx;

  localparam int FB = 408;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic          start;
  logic [FB-1:0] data;
  logic          busy, done, cs, sclk, mosi;
`ifdef SPI_TX_MISO_CAPTURE_EN
  logic [FB-1:0] rx_data;
  logic          rx_valid;
`endif

  spi_frame_tx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .start  (start),
    .DATA   (data),
    .busy   (busy),
    .done   (done),
    .CS     (cs),
    .SCLK   (sclk),
    .MOSI   (mosi)
`ifdef SPI_TX_MISO_CAPTURE_EN
    ,
    .MISO     (mosi),
    .RX_DATA  (rx_data),
    .RX_VALID (rx_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FB-1:0] data;
    int            cs_low;
    int            gap_before;
    int            done_hi;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model and monitor
  logic          cs_prev = 1'b1, sclk_prev = 1'b0, mosi_prev = 1'b0, done_prev = 1'b0;
  logic [FB-1:0] rx = '0;
  int            rises = 0, cs_low = 0, hi_cnt = 0, glitch = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rises  = 0;
      cs_low = 0;
      glitch = 0;
    end else begin
      if (cs_prev && !cs) begin
        rx     = '0;
        rises  = 0;
        cs_low = 0;
        glitch = 0;
        if (exp_q.size() > 0 && exp_q[0].gap_before != 0)
          chk_int("cs_gap_cycles", hi_cnt, exp_q[0].gap_before);
      end
      if (!cs) begin
        cs_low++;
        if (!sclk_prev && sclk) begin
          rx = {rx[FB-2:0], mosi};
          rises++;
        end
        if ((mosi !== mosi_prev) && !(sclk_prev && !sclk) && !cs_prev)
          glitch++;
      end else begin
        hi_cnt = cs_prev ? hi_cnt + 1 : 1;
        if (sclk) glitch++;
      end
      if (done && !done_prev) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk1("unexpected_done", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk_vec("frame_data", rx, e.data);
          chk_int("sclk_rises", rises, FB);
          chk_int("mosi_glitches", glitch, 0);
          chk1("busy_at_done", busy, 1'b1);
          if (e.cs_low != 0) chk_int("cs_low_cycles", cs_low, e.cs_low);
          if (e.done_hi != 0) chk_int("done_after_cs_rise", hi_cnt, e.done_hi);
`ifdef SPI_TX_MISO_CAPTURE_EN
          chk1("rx_valid_at_done", rx_valid, 1'b1);
          chk_vec("rx_data", rx_data, e.data);
`endif
        end
      end
    end
    cs_prev   = cs;
    sclk_prev = sclk;
    mosi_prev = mosi;
    done_prev = done;
  end

  task automatic wait_cs_low(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !cs;
    end
    chk1("cs_fall_seen", ok, 1'b1);
  endtask

  task automatic wait_done(input int target, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (done_cnt >= target);
    end
    chk1("done_seen", ok, 1'b1);
  endtask

  logic [FB-1:0] pat1, d0, d1, d2, pat_abort, pat_r, ones;
  int            base;
  bit            ok;

  initial begin
    pat1      = {64'h0123456789ABCDEF, {43{8'hA5}}};
    d0        = {51{8'h3C}};
    d1        = {64'hFEDCBA9876543210, {43{8'h5A}}};
    d2        = {{50{8'h00}}, 8'h81};
    pat_abort = {51{8'hF0}};
    pat_r     = {34{12'hC3A}};
    ones      = '1;

    // Reset held with start high: all outputs idle.
    rst_n  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b1;
    data   = pat1;
    repeat (4) begin
      @(negedge clk);
      chk1("rst_cs", cs, 1'b1);
      chk1("rst_sclk", sclk, 1'b0);
      chk1("rst_mosi", mosi, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
    end

    // Release: the frame starts on the first enabled edge.
    exp_q.push_back('{pat1, 3268, 0, 4});
    rst_n = 1'b1;
    @(negedge clk);
    chk1("cs_after_release", cs, 1'b0);
    chk1("busy_after_release", busy, 1'b1);
    chk1("mosi_first_bit", mosi, pat1[FB-1]);
    start = 1'b0;
    data  = ~pat1;
    // start pulses while busy are ignored.
    repeat (300) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, 5000);
    repeat (10) @(negedge clk);
    chk1("busy_after_done", busy, 1'b0);

    // Back-to-back frames with start held; DATA changes after each acceptance.
    base = done_cnt;
    exp_q.push_back('{d0, 3268, 0, 4});
    exp_q.push_back('{d1, 3268, 5, 4});
    exp_q.push_back('{d2, 3268, 5, 4});
    data  = d0;
    start = 1'b1;
    wait_cs_low(10);
    data = d1;
    wait_done(base + 1, 4000);
    wait_cs_low(20);
    data = d2;
    wait_done(base + 2, 4000);
    wait_cs_low(20);
    start = 1'b0;
    data  = pat1;
    wait_done(base + 3, 4000);
    repeat (20) @(negedge clk);

    // Reset during bit 100 aborts the frame without a done pulse.
    base  = done_cnt;
    data  = pat_abort;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (rises >= 100);
    end
    chk1("reached_bit100", ok, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("abort_cs", cs, 1'b1);
    chk1("abort_sclk", sclk, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_int("no_done_after_abort", done_cnt, base);
    exp_q.push_back('{ones, 3268, 0, 4});
    data  = ones;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data  = '0;
    wait_done(base + 1, 4000);
    repeat (10) @(negedge clk);

    // Random clock enable: same wire content, stretched timing.
    base = done_cnt;
    exp_q.push_back('{pat_r, 0, 0, 0});
    data  = pat_r;
    start = 1'b1;
    ok    = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (busy) start = 1'b0;
      clk_en = 1'($urandom_range(0, 1));
      ok = (done_cnt >= base + 1);
    end
    chk1("random_en_done_seen", ok, 1'b1);
    clk_en = 1'b1;
    start  = 1'b0;
    repeat (20) @(negedge clk);

    chk_int("done_total", done_cnt, 6);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
